// File: rtl/execution_sequencer_pkg.sv
// execution_sequencer_pkg: run-controller state type and default parameters
package execution_sequencer_pkg;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RESETTING,
        ST_ARMED,
        ST_EXECUTING,
        ST_DRAINING,
        ST_DONE
    } state_t;
    localparam int DEF_RESET_CYCLES     = 4;
    localparam int DEF_QUIESCENT_CYCLES = 8;
    localparam int DEF_COUNTER_WIDTH    = 32;
endpackage

// File: rtl/execution_sequencer_quiescence_detector.sv
// quiescence_detector: flags the cycle in which network/memory have been quiet for QUIESCENT_CYCLES in a row
module quiescence_detector
    import execution_sequencer_pkg::*;
#(
    parameter int QUIESCENT_CYCLES = DEF_QUIESCENT_CYCLES
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic channels_quiescent,
    input  logic routers_quiescent,
    input  logic memory_quiescent,
    output logic stable
);
    localparam int QW = $clog2(QUIESCENT_CYCLES + 1);
    logic [QW-1:0] r_count;
    logic          w_all;
    assign w_all  = channels_quiescent & routers_quiescent & memory_quiescent;
    // stable fires combinationally so the sequencer leaves DRAINING on the edge that completes the window
    assign stable = w_all && (r_count == QW'(QUIESCENT_CYCLES - 1));
    // consecutive quiet-cycle counter, restarts on any non-quiet cycle, saturates at the window length
    always_ff @(posedge clock) begin
        if (reset || clear) r_count <= '0;
        else if (!w_all) r_count <= '0;
        else if (r_count != QW'(QUIESCENT_CYCLES)) r_count <= r_count + QW'(1);
    end
endmodule

// File: rtl/execution_sequencer.sv
// execution_sequencer: reset/arm/execute/drain run controller for the processing block
// Optional quiescence drain phase enabled by EXECUTION_SEQUENCER_QUIESCENCE_CHECK_EN.
module execution_sequencer
    import execution_sequencer_pkg::*;
#(
    parameter int RESET_CYCLES     = DEF_RESET_CYCLES,
    parameter int QUIESCENT_CYCLES = DEF_QUIESCENT_CYCLES,
    parameter int COUNTER_WIDTH    = DEF_COUNTER_WIDTH
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     abort,
    input  logic [COUNTER_WIDTH-1:0] cycle_limit,
    input  logic                     block_halted,
    input  logic                     block_channels_quiescent,
    input  logic                     block_routers_quiescent,
    input  logic                     memory_quiescent,
    output logic                     system_reset,
    output logic                     system_enable,
    output logic                     system_execute,
    output logic                     system_halted,
    output logic                     busy,
    output logic                     timed_out,
    output logic [COUNTER_WIDTH-1:0] cycle_count
);
    localparam int RW = $clog2(RESET_CYCLES + 1);
    state_t                   r_state, w_next_state;
    logic [RW-1:0]            r_rst_cnt;
    logic [COUNTER_WIDTH-1:0] r_limit, r_count, w_count_inc;
    logic                     r_system_reset, r_system_enable, r_system_execute, r_system_halted;
    logic                     r_busy, r_timed_out;
    logic                     w_busy, w_run_start, w_counting, w_limit_hit, w_timeout;
`ifdef EXECUTION_SEQUENCER_QUIESCENCE_CHECK_EN
    localparam state_t HALT_NEXT = ST_DRAINING;
    logic w_stable;
    quiescence_detector #(
        .QUIESCENT_CYCLES(QUIESCENT_CYCLES)
    ) u_quiescence_detector (
        .clock              (clock),
        .reset              (reset),
        .clear              (r_state != ST_DRAINING),
        .channels_quiescent (block_channels_quiescent),
        .routers_quiescent  (block_routers_quiescent),
        .memory_quiescent   (memory_quiescent),
        .stable             (w_stable)
    );
`else
    localparam state_t HALT_NEXT = ST_DONE;
    logic w_unused_quiescent;
    assign w_unused_quiescent = &{block_channels_quiescent, block_routers_quiescent, memory_quiescent,
                                  QUIESCENT_CYCLES[0]};
`endif
    assign w_busy      = r_state inside {ST_RESETTING, ST_ARMED, ST_EXECUTING, ST_DRAINING};
    assign w_run_start = start && (r_state == ST_IDLE || r_state == ST_DONE);
    assign w_counting  = !abort && (r_state == ST_EXECUTING || r_state == ST_DRAINING);
    assign w_count_inc = (&r_count) ? r_count : r_count + COUNTER_WIDTH'(1);
    assign w_limit_hit = (r_limit != '0) && (w_count_inc == r_limit);
    // next-state selection; abort beats start, halt beats limit, quiescence beats limit
    always_comb begin
        w_next_state = r_state;
        w_timeout    = 1'b0;
        if (abort && w_busy) w_next_state = ST_IDLE;
        else case (r_state)
            ST_IDLE, ST_DONE: w_next_state = start ? ST_RESETTING : r_state;
            ST_RESETTING:     w_next_state = (r_rst_cnt == RW'(RESET_CYCLES - 1)) ? ST_ARMED : ST_RESETTING;
            ST_ARMED:         w_next_state = ST_EXECUTING;
            ST_EXECUTING: begin
                w_timeout    = !block_halted && w_limit_hit;
                w_next_state = block_halted ? HALT_NEXT : (w_limit_hit ? ST_DONE : ST_EXECUTING);
            end
`ifdef EXECUTION_SEQUENCER_QUIESCENCE_CHECK_EN
            ST_DRAINING: begin
                w_timeout    = !w_stable && w_limit_hit;
                w_next_state = (w_stable || w_limit_hit) ? ST_DONE : ST_DRAINING;
            end
`endif
            default:          w_next_state = ST_IDLE;
        endcase
    end
    // state, counters and Moore outputs decoded from the upcoming state so they are registered
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state          <= ST_IDLE;
            r_rst_cnt        <= '0;
            r_limit          <= '0;
            r_count          <= '0;
            r_timed_out      <= 1'b0;
            r_system_reset   <= 1'b0;
            r_system_enable  <= 1'b0;
            r_system_execute <= 1'b0;
            r_system_halted  <= 1'b0;
            r_busy           <= 1'b0;
        end else begin
            r_state          <= w_next_state;
            r_rst_cnt        <= (r_state == ST_RESETTING) ? r_rst_cnt + RW'(1) : '0;
            r_limit          <= w_run_start ? cycle_limit : r_limit;
            r_count          <= w_run_start ? '0 : (w_counting ? w_count_inc : r_count);
            r_timed_out      <= w_run_start ? 1'b0 : (r_timed_out | w_timeout);
            r_system_reset   <= w_next_state == ST_RESETTING;
            r_system_enable  <= w_next_state inside {ST_ARMED, ST_EXECUTING, ST_DRAINING};
            r_system_execute <= w_next_state == ST_EXECUTING;
            r_system_halted  <= w_next_state == ST_DONE;
            r_busy           <= w_next_state inside {ST_RESETTING, ST_ARMED, ST_EXECUTING, ST_DRAINING};
        end
    end
    assign system_reset   = r_system_reset;
    assign system_enable  = r_system_enable;
    assign system_execute = r_system_execute;
    assign system_halted  = r_system_halted;
    assign busy           = r_busy;
    assign timed_out      = r_timed_out;
    assign cycle_count    = r_count;
endmodule

// File: tb/tb_execution_sequencer.sv
// tb_execution_sequencer: directed and randomized runs checked against a run-length model of the sequencer
module tb_execution_sequencer;
    import execution_sequencer_pkg::*;
    localparam int RC = DEF_RESET_CYCLES;
    localparam int QC = DEF_QUIESCENT_CYCLES;
    localparam int CW = DEF_COUNTER_WIDTH;
`ifdef EXECUTION_SEQUENCER_QUIESCENCE_CHECK_EN
    localparam bit QEN = 1'b1;
`else
    localparam bit QEN = 1'b0;
`endif
    logic          clock = 1'b0;
    logic          reset, start, abort, halted_in, chq, rtq, memq;
    logic [CW-1:0] limit;
    logic          system_reset, system_enable, system_execute, system_halted, busy, timed_out;
    logic [CW-1:0] cycle_count;
    int            errors = 0;
    int            checks = 0;
    bit            q [1:64];

    always #5 clock = ~clock;

    execution_sequencer dut (
        .clock                    (clock),
        .reset                    (reset),
        .start                    (start),
        .abort                    (abort),
        .cycle_limit              (limit),
        .block_halted             (halted_in),
        .block_channels_quiescent (chq),
        .block_routers_quiescent  (rtq),
        .memory_quiescent         (memq),
        .system_reset             (system_reset),
        .system_enable            (system_enable),
        .system_execute           (system_execute),
        .system_halted            (system_halted),
        .busy                     (busy),
        .timed_out                (timed_out),
        .cycle_count              (cycle_count)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_ctl(input string tag, input bit r, input bit en, input bit ex, input bit hl, input bit bz);
        chk({tag, ".system_reset"}, 64'(system_reset), 64'(r));
        chk({tag, ".enable"}, 64'(system_enable), 64'(en));
        chk({tag, ".execute"}, 64'(system_execute), 64'(ex));
        chk({tag, ".halted"}, 64'(system_halted), 64'(hl));
        chk({tag, ".busy"}, 64'(busy), 64'(bz));
    endtask

    // h: execution cycle on which halt is first seen (0 = never); l: cycle limit (0 = unlimited)
    task automatic run(input string tag, input int h, input int l);
        int   e, total, exec_len, run_len, qi, exp_count;
        bit   tmo, halt_path;
        logic [2:0] qv;
        halt_path = (h != 0) && (l == 0 || h <= l);
        tmo       = 1'b0;
        if (!halt_path) begin
            exec_len = l;
            total    = l;
            tmo      = 1'b1;
        end else begin
            exec_len = h;
            total    = h;
            if (QEN) begin
                run_len = 0;
                for (int i = 1; i <= 64; i++) begin
                    run_len = q[i] ? run_len + 1 : 0;
                    if (run_len == QC) begin
                        total = h + i;
                        break;
                    end
                    if (l != 0 && h + i == l) begin
                        total = l;
                        tmo   = 1'b1;
                        break;
                    end
                end
            end
        end
        e     = RC + 2 + total;
        limit = CW'(l);
        start = 1'b1;
        abort = 1'b0;
        tick();
        start = 1'b0;
        for (int c = 1; c <= e; c++) begin
            exp_count = (c == e) ? total : ((c <= RC + 1) ? 0 : c - RC - 2);
            chk_ctl(tag, c <= RC, c > RC && c < e, c > RC + 1 && c <= RC + 1 + exec_len, c == e, c < e);
            chk({tag, ".count"}, 64'(cycle_count), 64'(exp_count));
            chk({tag, ".timed_out"}, 64'(timed_out), 64'((c == e) ? tmo : 1'b0));
            if (c < e) begin
                halted_in = halt_path && c >= RC + 1 + h;
                qi        = c - (RC + 1 + h);
                if (halt_path && qi >= 1 && qi <= 64) qv = q[qi] ? 3'b111 : 3'($urandom_range(0, 6));
                else qv = 3'($urandom);
                {chq, rtq, memq} = qv;
                start = ($urandom_range(0, 9) == 0);
                tick();
            end
        end
        start     = 1'b0;
        halted_in = 1'b0;
        tick();
        chk_ctl({tag, ".hold"}, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk({tag, ".hold.count"}, 64'(cycle_count), 64'(total));
        chk({tag, ".hold.timed_out"}, 64'(timed_out), 64'(tmo));
    endtask

    task automatic abort_run(input string tag, input int j, input bit with_start);
        limit     = '0;
        halted_in = 1'b0;
        start     = 1'b1;
        tick();
        start = 1'b0;
        repeat (RC + j) tick();
        chk({tag, ".pre.execute"}, 64'(system_execute), 64'(1));
        abort = 1'b1;
        start = with_start;
        tick();
        abort = 1'b0;
        start = 1'b0;
        chk_ctl(tag, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk({tag, ".count"}, 64'(cycle_count), 64'(j - 1));
        tick();
        chk_ctl({tag, ".idle"}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        abort     = 1'b0;
        halted_in = 1'b0;
        {chq, rtq, memq} = 3'b000;
        limit     = '0;
        repeat (2) tick();
        reset = 1'b0;
        chk_ctl("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("reset.count", 64'(cycle_count), 64'(0));
        chk("reset.timed_out", 64'(timed_out), 64'(0));
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk_ctl("idle_abort", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 64; i++) q[i] = 1'b1;
        run("nominal", 20, 0);
        q[6] = 1'b0;
        run("glitch", 20, 0);
        q[6] = 1'b1;
        run("timeout", 0, 100);
        run("halt_eq_limit", 30, 30);
        run("drain_timeout", 10, 14);
        run("drain_tie", 10, 18);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk_ctl("done_abort", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        abort_run("abort_exec", 5, 1'b0);
        abort_run("abort_start", 3, 1'b1);
        run("after_abort", 7, 0);
        limit = '0;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (RC + 3) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_ctl("mid_reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("mid_reset.count", 64'(cycle_count), 64'(0));
        for (int k = 0; k < 12; k++) begin
            int h, l;
            h = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 30));
            l = (h == 0) ? int'($urandom_range(1, 40)) : (($urandom_range(0, 1) == 1) ? 0 : int'($urandom_range(1, 40)));
            for (int i = 1; i <= 64; i++) q[i] = (i >= 40) || ($urandom_range(0, 5) != 0);
            run($sformatf("rand%0d", k), h, l);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/execution_sequencer.md
# execution_sequencer

Hardware run controller between the system control registers and the processing block/data memory. On a host start pulse it:
- holds the block in reset for a fixed window;
- enables and executes it while counting cycles;
- detects completion from halt plus a window of network/memory quiescence, or stops on a cycle limit or host abort.

It replaces driver-side polling of the raw halt flag and drives `system_reset`, `system_enable`, `system_execute` and `system_halted`.

## Interface
Parameters:
- RESET_CYCLES, 4: cycles `system_reset` is held high per run (≥1).
- QUIESCENT_CYCLES, 8: consecutive all-quiescent cycles required to finish (≥1).
- COUNTER_WIDTH, 32: width of `cycle_limit` and `cycle_count`.

Ports:
- clock  in  1  single clock, posedge.
- reset  in  1  synchronous, active-high.
- start  in  1  single-cycle run request from control registers.
- abort  in  1  single-cycle abort request.
- cycle_limit  in  COUNTER_WIDTH  max counted cycles; 0 = unlimited. Sampled on accepted start.
- block_halted  in  1  block halt flag.
- block_channels_quiescent, block_routers_quiescent, memory_quiescent  in  1 each.
- system_reset  out  1  block/memory reset.
- system_enable  out  1  block enable.
- system_execute  out  1  block execute.
- system_halted  out  1  run finished (done state).
- busy  out  1  run in progress.
- timed_out  out  1  last run ended by cycle limit.
- cycle_count  out  COUNTER_WIDTH  counted cycles of current/last run.

## Operation
- All outputs are registered (Moore). On `reset`, all outputs are 0, the state is IDLE and the counters are 0.
- States: IDLE, RESETTING, ARMED, EXECUTING, DRAINING, DONE.
- IDLE: all controls 0. A start moves to RESETTING, latches `cycle_limit`, clears `cycle_count`, `timed_out` and the quiescence counter.
- RESETTING: `system_reset`=1 for exactly RESET_CYCLES cycles, then ARMED.
- ARMED: `system_enable`=1, `system_execute`=0 for one cycle, then EXECUTING.
- EXECUTING: enable=1, execute=1, `cycle_count`++ each cycle.
  - If `block_halted`, go to DRAINING.
  - Otherwise, if the limit is nonzero and `cycle_count`==limit, go to DONE with `timed_out`=1.
- DRAINING: enable=1, execute=0, `cycle_count`++.
  - The quiescence counter increments while all three quiescent inputs are 1 and clears to 0 otherwise.
  - When it reaches QUIESCENT_CYCLES, go to DONE.
  - Else, on limit hit, go to DONE with `timed_out`=1. Completion wins over a same-cycle limit hit.
- DONE: enable=0, execute=0, `system_halted`=1. `cycle_count` and `timed_out` hold. A start begins a new run (RESETTING).
- `busy`=1 in RESETTING through DRAINING.
- Start while `busy` is ignored.
- Abort in any busy state: go to IDLE, controls 0, `system_halted`=0, `cycle_count` held. Abort wins over a same-cycle start. Abort in IDLE/DONE is ignored.
- `cycle_count` saturates at all-ones and never wraps.
- Halt and limit hit in the same EXECUTING cycle: halt wins.
- `reset` mid-run: IDLE immediately next cycle. Block state is undefined until the next run's RESETTING.

## Timing
- start sampled high at edge t, with t+1 the first RESETTING cycle:
  - `system_reset` high for cycles t+1 … t+RESET_CYCLES;
  - ARMED at t+RESET_CYCLES+1;
  - first EXECUTING cycle at t+RESET_CYCLES+2.
- Inputs are sampled each edge; their effect appears on outputs one cycle later.
- Last DRAINING quiescent cycle is c: DONE and `system_halted` at c+1.
- Abort sampled at edge t: controls low from t+1.

## Configuration
- EXECUTION_SEQUENCER_QUIESCENCE_CHECK_EN defined: DRAINING and the quiescence counter are built as above.
- Undefined: DRAINING and the quiescence counter are omitted.
  - `block_halted` in EXECUTING goes directly to DONE.
  - Quiescent inputs are unused.
  - This matches legacy halt-only behaviour.

## Structure
- Shared package `execution_sequencer_pkg` holds:
  - the state enum type;
  - default constants for RESET_CYCLES, QUIESCENT_CYCLES and COUNTER_WIDTH.
- One sub-module, `quiescence_detector`:
  - inputs: clock, reset, clear, three quiescent flags;
  - output: `stable`, asserted when the consecutive count reaches QUIESCENT_CYCLES;
  - instantiated only under the macro.

## Test plan
- Reset: assert `reset` 2 cycles, start=0 → all outputs 0, `busy`=0; abort in IDLE → no change.
- Nominal (macro on, quiescent inputs tied 1, limit 0): start at t → `system_reset` high t+1..t+4, execute from t+6; `block_halted` after 20 EXECUTING cycles → DRAINING 8 cycles → `system_halted`=1, `cycle_count`=28, `timed_out`=0.
- Quiescence glitch: in DRAINING, `memory_quiescent`=0 for one cycle after 5 quiescent cycles → counter restarts; DONE 9 cycles after the glitch cycle, `cycle_count`=20+5+1+8=34.
- Timeout: limit=100, `block_halted` never set → DONE with `timed_out`=1, `cycle_count`=100, execute low next cycle; halt and limit asserted in the same cycle → DRAINING, `timed_out`=0.
- Abort/start collisions:
  - start while `busy` → ignored, timing unchanged;
  - abort in EXECUTING → next cycle IDLE, enable=execute=0, `busy`=0;
  - abort+start same cycle in EXECUTING → IDLE.
- Macro off: halt after 20 cycles with quiescent inputs 0 → DONE next cycle, `cycle_count`=20.
